// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-side bundle of the machine-mode trap sequencer.
// master: pipeline + CSR array (drives decode/CSR state, consumes strobes)
// slave : trap_sequencer
interface trap_sequencer_if;
  logic        irq_ext;
  logic        irq_soft;
  logic        irq_timer;
  logic        csr_meie;
  logic        csr_msie;
  logic        csr_mtie;
  logic        csr_mstatus_mie;
  logic [29:0] csr_mtvec_ex;
  logic [29:0] csr_mepc_ex;
  logic        cpu_stat_ex;
  logic        illegal_ops_ex;
  logic        cmd_ecall_ex;
  logic        cmd_mret_ex;
  logic [29:0] pc_ex;
  logic        safe_pt;
  logic [29:0] pc_resume;
  logic        stall_req;
  logic        g_interrupt;
  logic        g_exception;
  logic [1:0]  g_interrupt_priv;
  logic [29:0] pc_excep;
  logic [3:0]  irq_cause;
  logic        redirect_valid;
  logic [29:0] redirect_pc;

  modport master (
    output irq_ext, irq_soft, irq_timer, csr_meie, csr_msie, csr_mtie,
           csr_mstatus_mie, csr_mtvec_ex, csr_mepc_ex, cpu_stat_ex,
           illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex, pc_ex, safe_pt, pc_resume,
    input  stall_req, g_interrupt, g_exception, g_interrupt_priv, pc_excep,
           irq_cause, redirect_valid, redirect_pc
  );

  modport slave (
    input  irq_ext, irq_soft, irq_timer, csr_meie, csr_msie, csr_mtie,
           csr_mstatus_mie, csr_mtvec_ex, csr_mepc_ex, cpu_stat_ex,
           illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex, pc_ex, safe_pt, pc_resume,
    output stall_req, g_interrupt, g_exception, g_interrupt_priv, pc_excep,
           irq_cause, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/return sequencer.
// Interrupts: 2-flop sync -> IDLE take -> DRAIN (until safe_pt) -> ENTER
// (g_interrupt strobe) -> VECTOR (redirect). Exceptions/mret jump straight to
// VECTOR from IDLE or DRAIN. Optional macro TRAP_VECTORED_EN: interrupts
// redirect to mtvec + cause (word offset); exceptions always go to mtvec.
module trap_sequencer #(
  parameter int HOLDOFF_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  trap_sequencer_if.slave  bus
);
  // Wide enough to hold HOLDOFF_CYC, never zero-width.
  localparam int HW = $clog2(HOLDOFF_CYC + 2);

  typedef enum logic [1:0] {IDLE, DRAIN, ENTER, VECTOR} state_t;
  typedef enum logic [1:0] {K_INT, K_EXC, K_MRET} kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [3:0]    cause_q, cause_d;
  logic [2:0]    sync1_q, sync2_q;
  logic [HW-1:0] hold_q;
  logic [2:0]    pend;
  logic          take;
  logic          sync_ok;
  logic [3:0]    cause_sel;
  logic [29:0]   target;

  assign pend    = sync2_q & {bus.csr_meie, bus.csr_msie, bus.csr_mtie};
  assign take    = (|pend) && bus.csr_mstatus_mie && (hold_q == '0);
  assign sync_ok = bus.cpu_stat_ex && (state_q == IDLE || state_q == DRAIN);
  // ext > soft > timer
  assign cause_sel = pend[2] ? 4'd11 : (pend[1] ? 4'd3 : 4'd7);

  // Redirect target is resolved in VECTOR from the latched trap kind.
  always_comb begin
    target = bus.csr_mtvec_ex;
    if (kind_q == K_MRET)
      target = bus.csr_mepc_ex;
`ifdef TRAP_VECTORED_EN
    else if (kind_q == K_INT)
      target = bus.csr_mtvec_ex + {26'd0, cause_q};
`endif
  end

  // Irq synchronizers (ext, soft, timer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.irq_ext, bus.irq_soft, bus.irq_timer};
      sync2_q <= sync1_q;
    end
  end

  // Holdoff after every redirect so the mstatus.MIE update lands first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hold_q <= '0;
    else if (state_q == VECTOR) hold_q <= HW'(HOLDOFF_CYC);
    else if (hold_q != '0)      hold_q <= hold_q - HW'(1);
  end

  // State, latched cause and trap kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= K_INT;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
    end
  end

  // Next state and Moore/Mealy outputs; sync events beat interrupts.
  always_comb begin
    state_d              = state_q;
    kind_d               = kind_q;
    cause_d              = cause_q;
    bus.stall_req        = 1'b0;
    bus.g_interrupt      = 1'b0;
    bus.g_exception      = 1'b0;
    bus.g_interrupt_priv = 2'b00;
    bus.pc_excep         = '0;
    bus.irq_cause        = '0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = '0;
    case (state_q)
      IDLE, DRAIN: begin
        bus.stall_req = (state_q == DRAIN);
        if (sync_ok && bus.illegal_ops_ex) begin
          bus.g_exception = 1'b1;
          bus.pc_excep    = bus.pc_ex;
          kind_d          = K_EXC;
          state_d         = VECTOR;
        end else if (sync_ok && bus.cmd_ecall_ex) begin
          // CSR array strobes ecall itself; only supply the PC.
          bus.pc_excep = bus.pc_ex;
          kind_d       = K_EXC;
          state_d      = VECTOR;
        end else if (sync_ok && bus.cmd_mret_ex) begin
          kind_d  = K_MRET;
          state_d = VECTOR;
        end else if (state_q == IDLE && take) begin
          cause_d = cause_sel;
          kind_d  = K_INT;
          state_d = DRAIN;
        end else if (state_q == DRAIN && bus.safe_pt) begin
          state_d = ENTER;
        end
      end
      ENTER: begin
        bus.stall_req        = 1'b1;
        bus.g_interrupt      = 1'b1;
        bus.g_interrupt_priv = 2'b11;
        bus.pc_excep         = bus.pc_resume;
        bus.irq_cause        = cause_q;
        state_d              = VECTOR;
      end
      VECTOR: begin
        bus.stall_req      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with an event scoreboard: every expected
// strobe (interrupt entry, exception, redirect) is queued when stimulus is
// applied and compared when the DUT pulses it.
module tb_trap_sequencer;
  localparam int HOLD = 2;
  localparam logic [29:0] MTVEC = 30'h40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  typedef struct {
    int          kind;   // 0 interrupt, 1 exception, 2 redirect
    logic [29:0] pc;
    logic [3:0]  cause;
  } exp_t;
  exp_t sbq[$];

  trap_sequencer_if bus();

  trap_sequencer #(.HOLDOFF_CYC(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [29:0] int_tgt(input logic [3:0] cause);
`ifdef TRAP_VECTORED_EN
    return MTVEC + {26'd0, cause};
`else
    return MTVEC + 30'd0 * {26'd0, cause};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [29:0] pc, input logic [3:0] cause);
    exp_t e;
    e.kind = kind; e.pc = pc; e.cause = cause;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Poll #1 after each edge for a signal; a timeout counts as a failure.
  task automatic wait_for(input int which, input string tag);
    logic hit;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      case (which)
        0:       hit = bus.g_interrupt;
        1:       hit = bus.g_exception;
        2:       hit = bus.redirect_valid;
        default: hit = bus.stall_req;
      endcase
      if (hit) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Scoreboard consumer: compare every strobe against the queue head.
  always @(negedge clk) begin
    int   nev;
    int   okind;
    exp_t e;
    if (rst_n) begin
      nev = int'(bus.g_interrupt) + int'(bus.g_exception) + int'(bus.redirect_valid);
      if (nev != 0) begin
        check("strobe_onehot", nev, 1);
        tests++;
        assert (sbq.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_strobe: got gi=%0b ge=%0b rv=%0b, want none",
                 bus.g_interrupt, bus.g_exception, bus.redirect_valid);
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          okind = bus.g_interrupt ? 0 : (bus.g_exception ? 1 : 2);
          check("sb_kind", okind, e.kind);
          if (okind == 0) begin
            check("sb_int_pc", {2'b0, bus.pc_excep}, {2'b0, e.pc});
            check("sb_int_cause", {28'd0, bus.irq_cause}, {28'd0, e.cause});
            check("sb_int_priv", {30'd0, bus.g_interrupt_priv}, 32'd3);
          end else if (okind == 1) begin
            check("sb_exc_pc", {2'b0, bus.pc_excep}, {2'b0, e.pc});
          end else begin
            check("sb_redir_pc", {2'b0, bus.redirect_pc}, {2'b0, e.pc});
          end
        end
      end
    end
  end

  initial begin
    int r;
    bus.irq_ext = 0; bus.irq_soft = 0; bus.irq_timer = 0;
    bus.csr_meie = 0; bus.csr_msie = 0; bus.csr_mtie = 0;
    bus.csr_mstatus_mie = 0;
    bus.csr_mtvec_ex = MTVEC; bus.csr_mepc_ex = 30'h0;
    bus.cpu_stat_ex = 0; bus.illegal_ops_ex = 0; bus.cmd_ecall_ex = 0;
    bus.cmd_mret_ex = 0; bus.pc_ex = 0; bus.safe_pt = 1; bus.pc_resume = 0;

    // Reset state
    #12;
    check("rst_flags", {27'd0, bus.stall_req, bus.g_interrupt, bus.g_exception,
                        bus.redirect_valid, bus.g_interrupt_priv != 2'b00}, 32'd0);
    check("rst_pc_excep", {2'b0, bus.pc_excep}, 32'd0);
    check("rst_redirect_pc", {2'b0, bus.redirect_pc}, 32'd0);
    @(negedge clk); rst_n = 1;
    step(2);

    // 1: external interrupt, safe_pt already high
    bus.csr_meie = 1; bus.csr_mstatus_mie = 1; bus.pc_resume = 30'h123;
    push(0, 30'h123, 4'd11); push(2, int_tgt(4'd11), 0);
    bus.irq_ext = 1;
    r = cyc;
    wait_for(0, "t1_gint");
    check("t1_latency", cyc - r, 4);
    bus.irq_ext = 0; bus.csr_mstatus_mie = 0;
    wait_for(2, "t1_redir");
    step(4);
    check("t1_drained", sbq.size(), 0);

    // ecall: pc_excep follows pc_ex, no g_exception, redirect to mtvec
    bus.cpu_stat_ex = 1; bus.cmd_ecall_ex = 1; bus.pc_ex = 30'h55;
    push(2, MTVEC, 0);
    #1;
    check("ecall_pc", {bus.g_exception, 1'b0, bus.pc_excep}, {2'b00, 30'h55});
    step(1);
    bus.cpu_stat_ex = 0; bus.cmd_ecall_ex = 0;
    step(4);

    // 2: soft + timer together -> soft first, timer after mret + holdoff
    bus.csr_msie = 1; bus.csr_mtie = 1; bus.csr_mstatus_mie = 1;
    bus.pc_resume = 30'h180;
    push(0, 30'h180, 4'd3); push(2, int_tgt(4'd3), 0);
    bus.irq_soft = 1; bus.irq_timer = 1;
    wait_for(0, "t2_gint");
    bus.irq_soft = 0; bus.csr_mstatus_mie = 0;
    wait_for(2, "t2_redir");
    step(4);
    bus.cpu_stat_ex = 1; bus.cmd_mret_ex = 1; bus.csr_mepc_ex = 30'h300;
    bus.csr_mstatus_mie = 1;
    push(2, 30'h300, 0); push(0, 30'h180, 4'd7); push(2, int_tgt(4'd7), 0);
    step(1);
    check("t2_mret_next", {31'd0, bus.redirect_valid}, 32'd1);
    bus.cpu_stat_ex = 0; bus.cmd_mret_ex = 0;
    wait_for(0, "t2_gint2");
    bus.irq_timer = 0; bus.csr_mstatus_mie = 0;
    wait_for(2, "t2_redir2");
    step(4);
    check("t2_drained", sbq.size(), 0);
    bus.csr_msie = 0;

    // 3: illegal op in DRAIN aborts timer entry, timer re-enters after holdoff
    bus.csr_mstatus_mie = 1; bus.safe_pt = 0; bus.pc_resume = 30'h2A0;
    bus.irq_timer = 1;
    wait_for(3, "t3_drain");
    bus.cpu_stat_ex = 1; bus.illegal_ops_ex = 1; bus.pc_ex = 30'h10;
    push(1, 30'h10, 0); push(2, MTVEC, 0);
    push(0, 30'h2A0, 4'd7); push(2, int_tgt(4'd7), 0);
    step(1);
    check("t3_exc_redir", {31'd0, bus.redirect_valid}, 32'd1);
    r = cyc;
    bus.cpu_stat_ex = 0; bus.illegal_ops_ex = 0; bus.safe_pt = 1;
    wait_for(0, "t3_gint");
    check("t3_holdoff_gap", cyc - r, HOLD + 3);
    bus.irq_timer = 0; bus.csr_mstatus_mie = 0;
    wait_for(2, "t3_redir");
    step(4);
    bus.csr_mtie = 0;

    // 4: mret with ext pending; entry only after holdoff
    bus.irq_ext = 1; bus.pc_resume = 30'h3C4;
    step(4);
    bus.cpu_stat_ex = 1; bus.cmd_mret_ex = 1; bus.csr_mepc_ex = 30'h200;
    bus.csr_mstatus_mie = 1;
    push(2, 30'h200, 0); push(0, 30'h3C4, 4'd11); push(2, int_tgt(4'd11), 0);
    step(1);
    check("t4_mret_next", {2'b0, bus.redirect_pc}, 32'h200);
    r = cyc;
    bus.cpu_stat_ex = 0; bus.cmd_mret_ex = 0;
    wait_for(0, "t4_gint");
    check("t4_holdoff_gap", cyc - r, HOLD + 3);
    bus.irq_ext = 0; bus.csr_mstatus_mie = 0;
    wait_for(2, "t4_redir");
    step(4);

    // 5: long DRAIN; line and MIE drop mid-drain, entry still completes
    bus.csr_mstatus_mie = 1; bus.safe_pt = 0; bus.pc_resume = 30'h77;
    bus.irq_ext = 1;
    wait_for(3, "t5_drain");
    bus.irq_ext = 0; bus.csr_mstatus_mie = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t5_drain_hold", {30'd0, bus.stall_req, bus.g_interrupt}, 32'd2);
    end
    push(0, 30'h77, 4'd11); push(2, int_tgt(4'd11), 0);
    bus.safe_pt = 1;
    wait_for(0, "t5_gint");
    wait_for(2, "t5_redir");
    step(4);

    // 6: async reset in DRAIN clears outputs at once
    bus.csr_mstatus_mie = 1; bus.safe_pt = 0; bus.irq_ext = 1;
    wait_for(3, "t6_drain");
    bus.irq_ext = 0; bus.csr_mstatus_mie = 0;
    rst_n = 0;
    #1;
    check("t6_rst_flags", {27'd0, bus.stall_req, bus.g_interrupt, bus.g_exception,
                           bus.redirect_valid, bus.g_interrupt_priv != 2'b00}, 32'd0);
    check("t6_rst_pc", {2'b0, bus.pc_excep | bus.redirect_pc}, 32'd0);
    @(negedge clk); rst_n = 1;
    bus.safe_pt = 1;
    step(6);
    check("t6_idle_after", {31'd0, bus.stall_req}, 32'd0);
    check("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
